// File: rtl/tail_light_monitor.sv
// tail_light_monitor
//   Passive checker for the six tail-light lamp lines. It decodes the
//   left/right turn sequence in progress, counts completed sequences, and
//   flags lamp patterns that break the legal sequence rules.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   la, lb, lc            left lamps (la innermost)
//   ra, rb, rc            right lamps (ra innermost)
//   clr                   synchronous clear of counters, err and err_code
//   left_active           left sequence in progress
//   right_active          right sequence in progress
//   phase                 lamps lit in the current sequence (0..3)
//   seq_done              one-cycle pulse on sequence completion
//   seq_dir               direction of last completed sequence (0 left, 1 right)
//   left_count            completed left sequences (saturating)
//   right_count           completed right sequences (saturating)
//   err                   sticky error flag
//   err_code              first error code since last clr/reset
//   err_count             number of error events (saturating)
module tail_light_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    input  logic             clr,
    output logic             left_active,
    output logic             right_active,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             seq_dir,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_L3,
        S_R1,
        S_R2,
        S_R3,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic             seq_done_q, seq_done_d;
    logic             seq_dir_q, seq_dir_d;
    logic [CNT_W-1:0] left_count_q, left_count_d;
    logic [CNT_W-1:0] right_count_q, right_count_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [5:0] v;
    logic       err_ev;
    logic [2:0] new_code;
    logic       done;
    logic       done_dir;

    assign v = {la, lb, lc, ra, rb, rc};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    // Next-state decode
    always_comb begin
        state_d  = state_q;
        err_ev   = 1'b0;
        new_code = 3'd0;
        done     = 1'b0;
        done_dir = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (v == 6'b000000)      state_d = S_IDLE;
                else if (v == 6'b100000) state_d = S_L1;
                else if (v == 6'b000100) state_d = S_R1;
                else begin
                    err_ev   = 1'b1;
                    new_code = 3'd1;
                end
            end
            S_L1: begin
                if (v == 6'b110000) state_d = S_L2;
                else begin
                    err_ev   = 1'b1;
                    new_code = 3'd2;
                end
            end
            S_L2: begin
                if (v == 6'b111000) state_d = S_L3;
                else begin
                    err_ev   = 1'b1;
                    new_code = 3'd2;
                end
            end
            S_L3: begin
                if (v == 6'b000000) begin
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    done_dir = 1'b0;
                end else begin
                    err_ev   = 1'b1;
                    new_code = 3'd4;
                end
            end
            S_R1: begin
                if (v == 6'b000110) state_d = S_R2;
                else begin
                    err_ev   = 1'b1;
                    new_code = 3'd3;
                end
            end
            S_R2: begin
                if (v == 6'b000111) state_d = S_R3;
                else begin
                    err_ev   = 1'b1;
                    new_code = 3'd3;
                end
            end
            S_R3: begin
                if (v == 6'b000000) begin
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    done_dir = 1'b1;
                end else begin
                    err_ev   = 1'b1;
                    new_code = 3'd4;
                end
            end
            S_ERR: begin
                // No new error events while parked here
                if (v == 6'b000000) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (err_ev) state_d = S_ERR;
    end

    // Counters and error bookkeeping; clr loses to a same-cycle error
    // event but wins over a same-cycle completion count.
    always_comb begin
        seq_done_d    = done;
        seq_dir_d     = done ? done_dir : seq_dir_q;
        left_count_d  = clr ? '0 : left_count_q;
        right_count_d = clr ? '0 : right_count_q;
        if (done && !clr) begin
            if (done_dir) right_count_d = sat_inc(right_count_q);
            else          left_count_d  = sat_inc(left_count_q);
        end

        err_d       = err_q;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        if (err_ev) begin
            err_d       = 1'b1;
            err_code_d  = (clr || !err_q) ? new_code : err_code_q;
            err_count_d = clr ? CNT_W'(1) : sat_inc(err_count_q);
        end else if (clr) begin
            err_d       = 1'b0;
            err_code_d  = 3'd0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            seq_done_q    <= 1'b0;
            seq_dir_q     <= 1'b0;
            left_count_q  <= '0;
            right_count_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            seq_done_q    <= seq_done_d;
            seq_dir_q     <= seq_dir_d;
            left_count_q  <= left_count_d;
            right_count_q <= right_count_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
        end
    end

    // Status decoded purely from the state register
    always_comb begin
        left_active  = 1'b0;
        right_active = 1'b0;
        phase        = 2'd0;
        case (state_q)
            S_L1: begin left_active  = 1'b1; phase = 2'd1; end
            S_L2: begin left_active  = 1'b1; phase = 2'd2; end
            S_L3: begin left_active  = 1'b1; phase = 2'd3; end
            S_R1: begin right_active = 1'b1; phase = 2'd1; end
            S_R2: begin right_active = 1'b1; phase = 2'd2; end
            S_R3: begin right_active = 1'b1; phase = 2'd3; end
            default: ;
        endcase
    end

    assign seq_done    = seq_done_q;
    assign seq_dir     = seq_dir_q;
    assign left_count  = left_count_q;
    assign right_count = right_count_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// tb_tail_light_monitor
//   Randomized plus directed stimulus; expected outputs come from a
//   sequence-position model and are queued, then popped and compared by a
//   separate monitor one clock edge later.
module tb_tail_light_monitor;

    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          la, lb, lc, ra, rb, rc;
    logic          clr;
    logic          left_active, right_active;
    logic [1:0]    phase;
    logic          seq_done, seq_dir;
    logic [CW-1:0] left_count, right_count, err_count;
    logic          err;
    logic [2:0]    err_code;

    tail_light_monitor #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .clr(clr),
        .left_active(left_active), .right_active(right_active),
        .phase(phase), .seq_done(seq_done), .seq_dir(seq_dir),
        .left_count(left_count), .right_count(right_count),
        .err(err), .err_code(err_code), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int la_o, ra_o, ph, done, dir, lc_o, rc_o, e, code, ec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Legal lamp steps; index 3 is the return to dark
    logic [5:0] lseq [4];
    logic [5:0] rseq [4];

    // Model: mode 0 idle, 1 left, 2 right, 3 error; step = lamps lit
    int m_mode, m_step, m_dir, m_lc, m_rc, m_err, m_code, m_ec;

    task automatic chk(input string name, input logic [31:0] got, input int expv);
        n_checks++;
        if (got !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic model_step(input logic [5:0] v, input bit c, input bit r);
        exp_t e;
        bit   ev   = 0;
        int   code = 0;
        bit   done = 0;
        if (r) begin
            m_mode = 0; m_step = 0; m_dir = 0; m_lc = 0; m_rc = 0;
            m_err = 0; m_code = 0; m_ec = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (v == lseq[0])      begin m_mode = 1; m_step = 1; end
                    else if (v == rseq[0]) begin m_mode = 2; m_step = 1; end
                    else if (v != 6'b0)    begin ev = 1; code = 1; end
                end
                1, 2: begin
                    logic [5:0] want;
                    want = (m_mode == 1) ? lseq[m_step] : rseq[m_step];
                    if (v == want) begin
                        if (m_step == 3) begin
                            done = 1; m_dir = (m_mode == 2);
                            m_mode = 0; m_step = 0;
                        end else m_step++;
                    end else begin
                        ev = 1;
                        code = (m_step == 3) ? 4 : ((m_mode == 1) ? 2 : 3);
                    end
                end
                default: if (v == 6'b0) m_mode = 0;
            endcase
            if (ev) begin m_mode = 3; m_step = 0; end
            if (c) begin m_lc = 0; m_rc = 0; end
            if (done && !c) begin
                if (m_dir) m_rc = (m_rc < MAX) ? m_rc + 1 : MAX;
                else       m_lc = (m_lc < MAX) ? m_lc + 1 : MAX;
            end
            if (ev) begin
                if (c || !m_err) m_code = code;
                m_ec  = c ? 1 : ((m_ec < MAX) ? m_ec + 1 : MAX);
                m_err = 1;
            end else if (c) begin
                m_err = 0; m_code = 0; m_ec = 0;
            end
        end
        e.la_o = (m_mode == 1);
        e.ra_o = (m_mode == 2);
        e.ph   = (m_mode == 1 || m_mode == 2) ? m_step : 0;
        e.done = done;
        e.dir  = m_dir;
        e.lc_o = m_lc; e.rc_o = m_rc;
        e.e = m_err; e.code = m_code; e.ec = m_ec;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic [5:0] v, input bit c = 0, input bit r = 0);
        @(negedge clk);
        {la, lb, lc, ra, rb, rc} = v;
        clr   = c;
        reset = r;
        model_step(v, c, r);
    endtask

    // Wait until the last driven cycle has been sampled
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every sampled edge produces one expected record
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("left_active",  32'(left_active),  e.la_o);
                chk("right_active", 32'(right_active), e.ra_o);
                chk("phase",        32'(phase),        e.ph);
                chk("seq_done",     32'(seq_done),     e.done);
                chk("seq_dir",      32'(seq_dir),      e.dir);
                chk("left_count",   32'(left_count),   e.lc_o);
                chk("right_count",  32'(right_count),  e.rc_o);
                chk("err",          32'(err),          e.e);
                chk("err_code",     32'(err_code),     e.code);
                chk("err_count",    32'(err_count),    e.ec);
            end
        end
    end

    task automatic left_seq(input bit clr_last = 0);
        for (int i = 0; i < 4; i++) cycle(lseq[i], (i == 3) && clr_last);
    endtask

    task automatic right_seq();
        for (int i = 0; i < 4; i++) cycle(rseq[i]);
    endtask

    initial begin
        lseq[0] = 6'b100000; lseq[1] = 6'b110000; lseq[2] = 6'b111000; lseq[3] = 6'b000000;
        rseq[0] = 6'b000100; rseq[1] = 6'b000110; rseq[2] = 6'b000111; rseq[3] = 6'b000000;
        {la, lb, lc, ra, rb, rc} = 6'b0;
        clr = 0;
        reset = 1;

        // Reset and idle
        cycle(6'b0, 0, 1);
        cycle(6'b0, 0, 1);
        repeat (5) cycle(6'b0);
        settle();
        chk("idle_phase", 32'(phase), 0);
        chk("idle_err", 32'(err), 0);

        // One left sequence
        left_seq();
        settle();
        chk("left_done", 32'(seq_done), 1);
        chk("left_dir", 32'(seq_dir), 0);
        chk("left_cnt1", 32'(left_count), 1);

        // Three right sequences after a clear
        cycle(6'b0, 1);
        repeat (3) right_seq();
        settle();
        chk("right_cnt3", 32'(right_count), 3);
        chk("right_dir", 32'(seq_dir), 1);
        chk("right_lcnt0", 32'(left_count), 0);

        // Repeated step is a break; ERR absorbs further bad patterns
        cycle(6'b0, 1);
        cycle(6'b100000);
        cycle(6'b100000);
        settle();
        chk("rep_code", 32'(err_code), 2);
        chk("rep_ecnt", 32'(err_count), 1);
        cycle(6'b000111);
        settle();
        chk("err_hold_ecnt", 32'(err_count), 1);
        cycle(6'b000000);
        settle();
        chk("err_exit_err", 32'(err), 1);

        // Saturation, then clear on the completing cycle
        repeat (4) left_seq();
        settle();
        chk("sat_lcnt", 32'(left_count), MAX);
        left_seq(1);
        settle();
        chk("clr_done", 32'(seq_done), 1);
        chk("clr_lcnt", 32'(left_count), 0);

        // Reset mid-sequence, both-sides error, clr with a new error
        cycle(6'b100000);
        cycle(6'b110000);
        cycle(6'b0, 0, 1);
        settle();
        chk("rst_err", 32'(err), 0);
        chk("rst_phase", 32'(phase), 0);
        cycle(6'b100100);
        settle();
        chk("both_code", 32'(err_code), 1);
        cycle(6'b000000);
        cycle(6'b001001, 1);
        settle();
        chk("clr_err_code", 32'(err_code), 1);
        chk("clr_err_cnt", 32'(err_count), 1);

        // Randomized traffic, biased towards legal sequences
        for (int n = 0; n < 800; n++) begin
            logic [5:0] v;
            int unsigned pick;
            pick = $urandom_range(0, 99);
            if (pick < 22) v = 6'($urandom_range(0, 63));
            else begin
                case (m_mode)
                    0:       v = (pick < 40) ? 6'b0 : ((pick < 70) ? lseq[0] : rseq[0]);
                    1:       v = lseq[m_step];
                    2:       v = rseq[m_step];
                    default: v = 6'b0;
                endcase
            end
            cycle(v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0));
        end

        cycle(6'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
